// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: size encodings, FSM states
// and byte-lane helpers.
package lsu_pkg;

  localparam int unsigned LANE_W  = 8;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned SHIFT_W = 5;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [LANE_W-1:0] LANE_MASK = 8'hFF;
  localparam logic [HALF_W-1:0] HALF_MASK = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_CAP,
    ST_WORD,
    RMW_READ,
    RMW_MERGE,
    FAULT
  } lsu_state_e;

  // Bit offset of a byte lane inside the little-endian word
  function automatic logic [SHIFT_W-1:0] laneShift(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

  // Lowest lane of the halfword containing the given byte address
  function automatic logic [1:0] halfBaseLane(input logic [1:0] addrLow);
    return {addrLow[1], 1'b0};
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus the word-addressed memory port of the load/store unit.
interface lsu_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [1:0]        ReqSize;
  logic              ReqUnsigned;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;

  logic              RespValid;
  logic [DATA_W-1:0] RespRData;
  logic              RespFault;

  logic [31:0]       MemAddress;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] MemWriteData;
  logic [DATA_W-1:0] MemReadData;

  // Environment side: the MEM stage issuing requests and the data memory answering reads
  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, MemReadData,
    input  ReqReady, RespValid, RespRData, RespFault,
           MemAddress, MemWrite, MemRead, MemWriteData
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqWData, MemReadData,
    output ReqReady, RespValid, RespRData, RespFault,
           MemAddress, MemWrite, MemRead, MemWriteData
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends load data, and merges sub-word
// store data into the old memory word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        addrLow,
  input  logic [1:0]        size,
  input  logic              isUnsigned,
  input  logic [DATA_W-1:0] oldWord,
  input  logic [DATA_W-1:0] newData,
  output logic [DATA_W-1:0] loadData,
  output logic [DATA_W-1:0] mergedWord
);

  logic [SHIFT_W-1:0] byteShift;
  logic [SHIFT_W-1:0] halfShift;
  logic [LANE_W-1:0]  byteVal;
  logic [HALF_W-1:0]  halfVal;
  logic [DATA_W-1:0]  byteMask;
  logic [DATA_W-1:0]  halfMask;

  always_comb begin
    byteShift  = laneShift(addrLow);
    halfShift  = laneShift(halfBaseLane(addrLow));
    byteVal    = LANE_W'(oldWord >> byteShift);
    halfVal    = HALF_W'(oldWord >> halfShift);
    byteMask   = DATA_W'(LANE_MASK) << byteShift;
    halfMask   = DATA_W'(HALF_MASK) << halfShift;
    loadData   = '0;
    mergedWord = oldWord;
    case (size)
      SZ_BYTE: begin
        loadData   = {{(DATA_W-LANE_W){byteVal[LANE_W-1] & ~isUnsigned}}, byteVal};
        mergedWord = (oldWord & ~byteMask)
                   | ((DATA_W'(newData[LANE_W-1:0]) << byteShift) & byteMask);
      end
      SZ_HALF: begin
        loadData   = {{(DATA_W-HALF_W){halfVal[HALF_W-1] & ~isUnsigned}}, halfVal};
        mergedWord = (oldWord & ~halfMask)
                   | ((DATA_W'(newData[HALF_W-1:0]) << halfShift) & halfMask);
      end
      SZ_WORD: begin
        loadData   = oldWord;
        mergedWord = newData;
      end
      default: begin
        loadData   = '0;
        mergedWord = oldWord;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory: alignment and
// range checks, read-modify-write for sub-word stores, extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 64
) (
  input logic    clock,
  input logic    reset_n,
  lsu_if.slave   bus
);

  lsu_state_e        state;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic              unsignedQ;
  logic [DATA_W-1:0] wdataQ;
  logic              respValidQ;
  logic              respFaultQ;
  logic [DATA_W-1:0] respRDataQ;

  logic              reqFault;
  logic              memRead;
  logic              memWrite;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] mergedWord;

  // Fault classification of the request currently presented
  always_comb begin
    reqFault = 1'b0;
    case (bus.ReqSize)
      SZ_BYTE: reqFault = 1'b0;
      SZ_HALF: reqFault = bus.ReqAddr[0];
      SZ_WORD: reqFault = |bus.ReqAddr[1:0];
      default: reqFault = 1'b1;
    endcase
    if (32'(bus.ReqAddr[ADDR_W-1:2]) >= 32'(MEM_DEPTH)) begin
      reqFault = 1'b1;
    end
  end

  lsu_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .addrLow   (addrQ[1:0]),
    .size      (sizeQ),
    .isUnsigned(unsignedQ),
    .oldWord   (bus.MemReadData),
    .newData   (wdataQ),
    .loadData  (loadData),
    .mergedWord(mergedWord)
  );

  // FSM, latched request fields and response registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addrQ      <= '0;
      sizeQ      <= SZ_BYTE;
      unsignedQ  <= 1'b0;
      wdataQ     <= '0;
      respValidQ <= 1'b0;
      respFaultQ <= 1'b0;
      respRDataQ <= '0;
    end else begin
      respValidQ <= 1'b0;
      respFaultQ <= 1'b0;
      respRDataQ <= '0;
      case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            addrQ     <= bus.ReqAddr;
            sizeQ     <= bus.ReqSize;
            unsignedQ <= bus.ReqUnsigned;
            wdataQ    <= bus.ReqWData;
            if (reqFault)               state <= FAULT;
            else if (!bus.ReqWrite)     state <= LOAD;
            else if (bus.ReqSize == SZ_WORD) state <= ST_WORD;
            else                        state <= RMW_READ;
          end
        end
        LOAD:     state <= LOAD_CAP;
        LOAD_CAP: begin
          respValidQ <= 1'b1;
          respRDataQ <= loadData;
          state      <= IDLE;
        end
        ST_WORD: begin
          respValidQ <= 1'b1;
          state      <= IDLE;
        end
        RMW_READ: state <= RMW_MERGE;
        RMW_MERGE: begin
          respValidQ <= 1'b1;
          state      <= IDLE;
        end
        FAULT: begin
          respValidQ <= 1'b1;
          respFaultQ <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from state so reset drops them immediately
  assign memRead  = (state == LOAD) || (state == RMW_READ);
  assign memWrite = (state == ST_WORD) || (state == RMW_MERGE);

  assign bus.ReqReady     = (state == IDLE);
  assign bus.RespValid    = respValidQ;
  assign bus.RespFault    = respFaultQ;
  assign bus.RespRData    = respRDataQ;
  assign bus.MemRead      = memRead;
  assign bus.MemWrite     = memWrite;
  assign bus.MemAddress   = 32'({2'b00, addrQ[ADDR_W-1:2]});
  assign bus.MemWriteData = memWrite ? mergedWord : '0;

endmodule
